// File: rtl/pipelined_dual_port_ram.sv
// Simple dual-port RAM with byte-lane writes, a 1..4 stage registered read pipeline,
// selectable read-during-write policy and out-of-range detection on both ports.
module pipelined_dual_port_ram #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    BYTE_WIDTH   = 8,
  parameter int    ADDR_WIDTH   = 9,
  parameter int    SIZE         = 512,
  parameter int    READ_LATENCY = 1,
  parameter string RDW_MODE     = "READ_FIRST",
  parameter string RAM_STYLE    = "auto",
  localparam int   NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_din,
  input  logic [NUM_BYTES-1:0]  wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dout,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic                  wr_err
);

  localparam bit WRITE_FIRST = (RDW_MODE == "WRITE_FIRST");
  localparam logic [ADDR_WIDTH:0] SIZE_LIMIT = (ADDR_WIDTH + 1)'(SIZE);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("pipelined_dual_port_ram: READ_LATENCY must be within 1..4");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("pipelined_dual_port_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (longint'(SIZE) > (64'd1 << ADDR_WIDTH)) begin : g_bad_size
    $error("pipelined_dual_port_ram: SIZE exceeds the address space");
  end
  if (RDW_MODE != "READ_FIRST" && RDW_MODE != "WRITE_FIRST") begin : g_bad_mode
    $error("pipelined_dual_port_ram: RDW_MODE must be READ_FIRST or WRITE_FIRST");
  end

  (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [SIZE];

  logic                  wr_oob;
  logic                  wr_ok;
  logic                  rd_oob;
  logic                  collide;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] ram_word;
  logic [DATA_WIDTH-1:0] rd_word_next;

  logic [READ_LATENCY-1:0] valid_reg;
  logic [READ_LATENCY-1:0] err_reg;
  logic [DATA_WIDTH-1:0]   data_reg [READ_LATENCY];
  logic                    wr_err_reg;

  assign wr_oob  = !({1'b0, wr_addr} < SIZE_LIMIT);
  assign wr_ok   = wr_en && !wr_oob;
  assign rd_oob  = !({1'b0, rd_addr} < SIZE_LIMIT);
  // Out-of-range reads are steered to word 0 so the array is never indexed past its end.
  assign rd_idx  = rd_oob ? '0 : rd_addr;
  assign ram_word = mem[rd_idx];
  assign collide = WRITE_FIRST && wr_ok && (rd_addr == wr_addr);

  // Per-lane bypass: a WRITE_FIRST collision takes the incoming byte, otherwise the stored one.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
    localparam int LO = gi * BYTE_WIDTH;
    assign rd_word_next[LO +: BYTE_WIDTH] =
      rd_oob               ? '0 :
      (collide && wr_be[gi]) ? wr_din[LO +: BYTE_WIDTH] :
                             ram_word[LO +: BYTE_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Data registers only advance behind a valid entry, so the output holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg  <= '0;
      err_reg    <= '0;
      wr_err_reg <= 1'b0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        data_reg[s] <= '0;
      end
    end else begin
      valid_reg[0] <= rd_en;
      err_reg[0]   <= rd_en && rd_oob;
      if (rd_en) begin
        data_reg[0] <= rd_word_next;
      end
      for (int s = 1; s < READ_LATENCY; s++) begin
        valid_reg[s] <= valid_reg[s-1];
        err_reg[s]   <= err_reg[s-1];
        if (valid_reg[s-1]) begin
          data_reg[s] <= data_reg[s-1];
        end
      end
      wr_err_reg <= wr_en && wr_oob;
    end
  end

  assign rd_dout  = data_reg[READ_LATENCY-1];
  assign rd_valid = valid_reg[READ_LATENCY-1];
  assign rd_err   = err_reg[READ_LATENCY-1];
  assign wr_err   = wr_err_reg;

endmodule

// File: tb/tb_pipelined_dual_port_ram.sv
// Directed bench for pipelined_dual_port_ram: four instances (latency 1..4, the last one
// WRITE_FIRST) share one stimulus stream and are checked against hand-computed values.
module tb_pipelined_dual_port_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [8:0]  wr_addr = '0;
  logic [31:0] wr_din = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [8:0]  rd_addr = '0;

  logic [31:0] dout [4];
  logic [3:0]  valid;
  logic [3:0]  err;
  logic [3:0]  werr;

  int errors = 0;
  int checks = 0;

  int          got_count [4];
  int          got_cycle [4];
  logic [31:0] got_data  [4];
  logic        got_err   [4];
  logic        got_werr0 [4];
  logic        got_werr1 [4];
  logic [31:0] got_hold  [4];

  always #5 clk = ~clk;

  pipelined_dual_port_ram #(.SIZE(300), .READ_LATENCY(1), .RDW_MODE("READ_FIRST")) u_l1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(dout[0]), .rd_valid(valid[0]),
    .rd_err(err[0]), .wr_err(werr[0]));
  pipelined_dual_port_ram #(.SIZE(300), .READ_LATENCY(2), .RDW_MODE("READ_FIRST")) u_l2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(dout[1]), .rd_valid(valid[1]),
    .rd_err(err[1]), .wr_err(werr[1]));
  pipelined_dual_port_ram #(.SIZE(300), .READ_LATENCY(3), .RDW_MODE("READ_FIRST")) u_l3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(dout[2]), .rd_valid(valid[2]),
    .rd_err(err[2]), .wr_err(werr[2]));
  pipelined_dual_port_ram #(.SIZE(300), .READ_LATENCY(4), .RDW_MODE("WRITE_FIRST")) u_l4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(dout[3]), .rd_valid(valid[3]),
    .rd_err(err[3]), .wr_err(werr[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request cycle, then 7 cycles of observation per instance (cycle 0 = right after the accepting edge).
  task automatic access(input bit do_wr, input logic [8:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input bit do_rd, input logic [8:0] ra);
    wr_en = do_wr; wr_addr = wa; wr_din = wd; wr_be = be;
    rd_en = do_rd; rd_addr = ra;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got_count[i] = 0; got_cycle[i] = -1; got_data[i] = '0; got_err[i] = 1'b0;
    end
    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (valid[i]) begin
          got_count[i]++; got_cycle[i] = c; got_data[i] = dout[i]; got_err[i] = err[i];
        end
        if (c == 0) got_werr0[i] = werr[i];
        if (c == 1) got_werr1[i] = werr[i];
      end
      tick();
    end
    for (int i = 0; i < 4; i++) got_hold[i] = dout[i];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout[i] !== 32'h0) begin
        errors++; $display("FAIL reset_dout inst%0d: got %h expected 00000000", i, dout[i]);
      end
      checks++;
      if ({valid[i], err[i], werr[i]} !== 3'b000) begin
        errors++; $display("FAIL reset_flags inst%0d: got %b expected 000", i, {valid[i], err[i], werr[i]});
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (valid !== 4'b0000) begin
      errors++; $display("FAIL reset_idle_valid: got %b expected 0000", valid);
    end
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_basic();
    access(1'b1, 9'd5, 32'hDEADBEEF, 4'hF, 1'b0, 9'd0);
    checks++;
    if (got_werr0[2] !== 1'b0) begin
      errors++; $display("FAIL basic_no_wr_err: got %b expected 0", got_werr0[2]);
    end
    access(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd5);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_count[i] !== 1 || got_cycle[i] !== i) begin
        errors++; $display("FAIL basic_timing inst%0d: got %0d pulses at cycle %0d expected 1 at %0d",
                           i, got_count[i], got_cycle[i], i);
      end
      checks++;
      if (got_data[i] !== 32'hDEADBEEF || got_err[i] !== 1'b0) begin
        errors++; $display("FAIL basic_data inst%0d: got %h err %b expected deadbeef err 0",
                           i, got_data[i], got_err[i]);
      end
    end
    checks++;
    if (got_hold[2] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_hold: got %h expected deadbeef", got_hold[2]);
    end
    $display("test_basic done: errors=%0d", errors);
  endtask

  task automatic test_byte_enables();
    access(1'b1, 9'd7, 32'h11223344, 4'hF, 1'b0, 9'd0);
    access(1'b1, 9'd7, 32'hAABBCCDD, 4'b0101, 1'b0, 9'd0);
    access(1'b1, 9'd7, 32'h00000000, 4'b0000, 1'b0, 9'd0);
    access(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd7);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_count[i] !== 1 || got_data[i] !== 32'h11BB33DD) begin
        errors++; $display("FAIL byte_enable inst%0d: got %h (%0d pulses) expected 11bb33dd",
                           i, got_data[i], got_count[i]);
      end
    end
    $display("test_byte_enables done: errors=%0d", errors);
  endtask

  task automatic test_collision();
    logic [31:0] exp;
    access(1'b1, 9'd9, 32'h00000000, 4'hF, 1'b0, 9'd0);
    access(1'b1, 9'd9, 32'hFFFFFFFF, 4'hF, 1'b1, 9'd9);
    for (int i = 0; i < 4; i++) begin
      exp = (i == 3) ? 32'hFFFFFFFF : 32'h00000000;
      checks++;
      if (got_count[i] !== 1 || got_data[i] !== exp) begin
        errors++; $display("FAIL collision_same_cycle inst%0d: got %h expected %h", i, got_data[i], exp);
      end
    end
    access(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd9);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_count[i] !== 1 || got_data[i] !== 32'hFFFFFFFF) begin
        errors++; $display("FAIL collision_next_cycle inst%0d: got %h expected ffffffff", i, got_data[i]);
      end
    end
    $display("test_collision done: errors=%0d", errors);
  endtask

  task automatic test_bounds();
    access(1'b1, 9'd44, 32'h12345678, 4'hF, 1'b0, 9'd0);
    access(1'b1, 9'd300, 32'hCAFEF00D, 4'hF, 1'b0, 9'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_werr0[i] !== 1'b1 || got_werr1[i] !== 1'b0) begin
        errors++; $display("FAIL wr_err_pulse inst%0d: got %b%b expected 10", i, got_werr0[i], got_werr1[i]);
      end
    end
    access(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd44);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_count[i] !== 1 || got_data[i] !== 32'h12345678) begin
        errors++; $display("FAIL bounds_no_alias inst%0d: got %h expected 12345678", i, got_data[i]);
      end
    end
    access(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd511);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_count[i] !== 1 || got_err[i] !== 1'b1 || got_data[i] !== 32'h0) begin
        errors++; $display("FAIL rd_oob inst%0d: got %h err %b (%0d pulses) expected 00000000 err 1",
                           i, got_data[i], got_err[i], got_count[i]);
      end
    end
    $display("test_bounds done: errors=%0d", errors);
  endtask

  task automatic test_reset_midstream();
    bit seen = 1'b0;
    logic [8:0] addrs [3];
    addrs[0] = 9'd5; addrs[1] = 9'd7; addrs[2] = 9'd44;
    for (int k = 0; k < 3; k++) begin
      rd_en = 1'b1; rd_addr = addrs[k];
      tick();
      if (valid[3]) seen = 1'b1;
    end
    rd_en = 1'b0;
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 9'd5; wr_din = 32'h0; wr_be = 4'hF;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout[i] !== 32'h0 || {valid[i], err[i], werr[i]} !== 3'b000) begin
        errors++; $display("FAIL midreset_outputs inst%0d: got %h flags %b expected 00000000 flags 000",
                           i, dout[i], {valid[i], err[i], werr[i]});
      end
    end
    for (int c = 0; c < 6; c++) begin
      if (valid[3]) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midreset_dropped: got rd_valid=1 expected none from flushed reads");
    end
    access(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd5);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_count[i] !== 1 || got_data[i] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL midreset_mem5 inst%0d: got %h expected deadbeef", i, got_data[i]);
      end
    end
    access(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd7);
    checks++;
    if (got_data[3] !== 32'h11BB33DD) begin
      errors++; $display("FAIL midreset_mem7: got %h expected 11bb33dd", got_data[3]);
    end
    $display("test_reset_midstream done: errors=%0d", errors);
  endtask

  task automatic test_back_to_back();
    int n [4];
    int first [4];
    int last [4];
    for (int a = 0; a < 64; a++) begin
      wr_en = 1'b1; wr_addr = 9'(a); wr_din = 32'(a); wr_be = 4'hF;
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n[i] = 0; first[i] = -1; last[i] = -1;
    end
    for (int cyc = 0; cyc < 72; cyc++) begin
      rd_en = (cyc < 64); rd_addr = 9'(cyc);
      tick();
      for (int i = 0; i < 4; i++) begin
        if (valid[i]) begin
          checks++;
          if (dout[i] !== 32'(n[i])) begin
            errors++; $display("FAIL stream_data inst%0d: got %h expected %h", i, dout[i], 32'(n[i]));
          end
          if (n[i] == 0) first[i] = cyc;
          last[i] = cyc;
          n[i]++;
        end
      end
    end
    rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (n[i] !== 64 || first[i] !== i || last[i] - first[i] !== 63) begin
        errors++; $display("FAIL stream_shape inst%0d: got %0d pulses cycles %0d..%0d expected 64 at %0d..%0d",
                           i, n[i], first[i], last[i], i, i + 63);
      end
    end
    $display("test_back_to_back done: errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_enables();
    test_collision();
    test_bounds();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
